// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
// Slot state enum is only used when STREAM_DEMUX_SKID_EN is defined.
package stream_demux_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } slot_state_e;

endpackage

// File: rtl/stream_slot.sv
// One registered output buffer of the demux.
// STREAM_DEMUX_SKID_EN selects a 2-entry skid buffer; otherwise a 1-entry register.
module stream_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

`ifdef STREAM_DEMUX_SKID_EN
  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  // Ready comes from state only, breaking the out_ready -> in_ready path.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    push    = in_valid && in_ready;
    pop     = out_valid && out_ready;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
`else
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Accept when empty or when the held beat leaves on this same edge.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`endif

endmodule

// File: rtl/stream_demux.sv
// Routes each input beat to one of N_OUT buffered output streams by in_sel.
// Define STREAM_DEMUX_SKID_EN for 2-entry skid slots (registered in_ready).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  logic [N_OUT-1:0]      slot_valid;
  logic [N_OUT-1:0]      slot_ready;
  logic                  in_range;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    in_range   = (32'(in_sel) < N_OUT);
    slot_valid = '0;
    // Out-of-range selects are always accepted and discarded.
    in_ready   = 1'b1;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(in_sel) == k) begin
        slot_valid[k] = in_valid;
        in_ready      = slot_ready[k];
      end
    end
    drop       = in_valid && !in_range;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (slot_valid[k]),
      .in_ready (slot_ready[k]),
      .in_data  (in_data),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .out_data (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
